// File: rtl/pixel_axi_burst_writer.sv
// Purpose: writes a frame of packed pixels to memory as a sequence of fixed-length AXI4 write bursts.
// Latency: W data is a zero-latency pass-through from the pixel stream. AW and B handshakes use registered valid/ready.
// Backpressure: pix_ready_o follows s_wready_i only while in W. AW is held until s_awready_i. One burst is in flight at a time.
//
// Ports:
//   clk, rst_n                       clock and asynchronous active-low reset
//   frame_start_i, base_addr_i,      frame request; base and burst count are sampled when the request is accepted
//   frame_bursts_i
//   pix_data_i/pix_valid_i/pix_ready_o   packed-pixel input stream
//   s_aw*, s_w*, s_b*                AXI4 write address, data and response channels (master side)
//   busy_o, frame_done_o, resp_err_o status: frame in progress, completion pulse, sticky error on a non-OKAY response
module pixel_axi_burst_writer #(
    parameter int DATA_W            = 32,
    parameter int ADDR_W            = 32,
    parameter int MST_ID_W          = 5,
    parameter int TRANS_DATA_LEN_W  = 8,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int TRANS_RESP_W      = 2,
    parameter int BURST_LEN         = 16,
    parameter int MST_ID            = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_start_i,
    input  logic [ADDR_W-1:0]            base_addr_i,
    input  logic [15:0]                  frame_bursts_i,
    input  logic [DATA_W-1:0]            pix_data_i,
    input  logic                         pix_valid_i,
    output logic                         pix_ready_o,
    output logic [MST_ID_W-1:0]          s_awid_o,
    output logic [ADDR_W-1:0]            s_awaddr_o,
    output logic [TRANS_DATA_LEN_W-1:0]  s_awlen_o,
    output logic [TRANS_DATA_SIZE_W-1:0] s_awsize_o,
    output logic                         s_awvalid_o,
    input  logic                         s_awready_i,
    output logic [DATA_W-1:0]            s_wdata_o,
    output logic                         s_wlast_o,
    output logic                         s_wvalid_o,
    input  logic                         s_wready_i,
    input  logic [MST_ID_W-1:0]          s_bid_i,
    input  logic [TRANS_RESP_W-1:0]      s_bresp_i,
    input  logic                         s_bvalid_i,
    output logic                         s_bready_o,
    output logic                         busy_o,
    output logic                         frame_done_o,
    output logic                         resp_err_o
);

    localparam int AWSIZE = $clog2(DATA_W / 8);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [TRANS_DATA_SIZE_W-1:0] AWSIZE_V  = TRANS_DATA_SIZE_W'(AWSIZE);
    localparam logic [TRANS_DATA_LEN_W-1:0]  AWLEN_V   = TRANS_DATA_LEN_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]            ADDR_INC  = ADDR_W'(BURST_LEN * (DATA_W / 8));
    // Clears the byte-offset bits so every burst starts on a data-word boundary.
    localparam logic [ADDR_W-1:0]            ADDR_MASK = ~((ADDR_W'(1) << AWSIZE) - ADDR_W'(1));
    localparam logic [BEAT_W-1:0]            LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cur_addr_q;
    logic [15:0]         frame_bursts_q;
    logic [15:0]         burst_cnt_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic                awvalid_q;
    logic                bready_q;
    logic                frame_done_q;
    logic                resp_err_q;

    logic                in_w;
    logic                beat_fire;
    logic                unused_bid;

    // Response ID is not needed: only one burst is ever outstanding.
    assign unused_bid = ^s_bid_i;

    // W channel is a direct pass-through, gated so no pixel moves outside W.
    assign in_w        = (state_q == ST_W);
    assign s_wdata_o   = pix_data_i;
    assign s_wvalid_o  = in_w & pix_valid_i;
    assign pix_ready_o = in_w & s_wready_i;
    assign s_wlast_o   = in_w && (beat_cnt_q == LAST_BEAT);
    assign beat_fire   = in_w & pix_valid_i & s_wready_i;

    assign s_awid_o     = MST_ID_W'(MST_ID);
    assign s_awaddr_o   = cur_addr_q;
    assign s_awlen_o    = AWLEN_V;
    assign s_awsize_o   = AWSIZE_V;
    assign s_awvalid_o  = awvalid_q;
    assign s_bready_o   = bready_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = frame_done_q;
    assign resp_err_o   = resp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cur_addr_q     <= '0;
            frame_bursts_q <= '0;
            burst_cnt_q    <= '0;
            beat_cnt_q     <= '0;
            awvalid_q      <= 1'b0;
            bready_q       <= 1'b0;
            frame_done_q   <= 1'b0;
            resp_err_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        resp_err_q <= 1'b0;
                        if (frame_bursts_i != 16'd0) begin
                            cur_addr_q     <= base_addr_i & ADDR_MASK;
                            frame_bursts_q <= frame_bursts_i;
                            burst_cnt_q    <= '0;
                            beat_cnt_q     <= '0;
                            awvalid_q      <= 1'b1;
                            state_q        <= ST_AW;
                        end else begin
                            // Empty frame: complete immediately without touching the bus.
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                ST_AW: begin
                    if (s_awready_i) begin
                        awvalid_q <= 1'b0;
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (beat_fire) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q <= '0;
                            bready_q   <= 1'b1;
                            state_q    <= ST_B;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                        end
                    end
                end
                ST_B: begin
                    if (s_bvalid_i) begin
                        bready_q    <= 1'b0;
                        burst_cnt_q <= burst_cnt_q + 16'd1;
                        cur_addr_q  <= (cur_addr_q + ADDR_INC) & ADDR_MASK;
                        if (s_bresp_i != '0) begin
                            resp_err_q <= 1'b1;
                        end
                        if (burst_cnt_q == frame_bursts_q - 16'd1) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            awvalid_q <= 1'b1;
                            state_q   <= ST_AW;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_axi_burst_writer.sv
module tb_pixel_axi_burst_writer;

    localparam logic [31:0] PIX_BASE = 32'hA500_0000;

    logic        clk;
    logic        rst_n;
    logic        frame_start_i;
    logic [31:0] base_addr_i;
    logic [15:0] frame_bursts_i;
    logic [31:0] pix_data_i;
    logic        pix_valid_i;
    logic        pix_ready_o;
    logic [4:0]  s_awid_o;
    logic [31:0] s_awaddr_o;
    logic [7:0]  s_awlen_o;
    logic [2:0]  s_awsize_o;
    logic        s_awvalid_o;
    logic        s_awready_i;
    logic [31:0] s_wdata_o;
    logic        s_wlast_o;
    logic        s_wvalid_o;
    logic        s_wready_i;
    logic [4:0]  s_bid_i;
    logic [1:0]  s_bresp_i;
    logic        s_bvalid_i;
    logic        s_bready_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        resp_err_o;

    pixel_axi_burst_writer #(.BURST_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_start_i(frame_start_i), .base_addr_i(base_addr_i), .frame_bursts_i(frame_bursts_i),
        .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .s_awid_o(s_awid_o), .s_awaddr_o(s_awaddr_o), .s_awlen_o(s_awlen_o), .s_awsize_o(s_awsize_o),
        .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i),
        .s_wdata_o(s_wdata_o), .s_wlast_o(s_wlast_o), .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i),
        .s_bid_i(s_bid_i), .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .resp_err_o(resp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard queues: expected AW addresses and expected W beats {last, data}.
    logic [31:0] aw_exp[$];
    logic [32:0] w_exp[$];
    logic [1:0]  resp_q[$];

    // Slave / pixel-source control knobs.
    int   aw_hold   = 0;
    bit   wr_rand   = 0;
    bit   pv_toggle = 0;
    int   pix_idx   = 0;

    // Monitor state.
    int   cyc = 0, w_total = 0, b_total = 0, last_b_cyc = 0, done_cyc = 0, done_cnt = 0;
    logic prev_done = 1'b0;
    logic w_f = 1'b0, wl_f = 1'b0, b_f = 1'b0;

    // Monitor: samples on the falling edge, pops and compares on every handshake.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            w_f  = rst_n & s_wvalid_o & s_wready_i;
            wl_f = w_f & s_wlast_o;
            b_f  = rst_n & s_bvalid_i & s_bready_o;
            if (rst_n) begin
                if (s_awvalid_o && s_awready_i) begin
                    if (aw_exp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL aw_extra actual=%0h required=no_aw", s_awaddr_o);
                    end else begin
                        chk("aw_addr", s_awaddr_o, aw_exp.pop_front());
                        chk("aw_len", 32'(s_awlen_o), 32'd3);
                        chk("aw_size", 32'(s_awsize_o), 32'd2);
                        chk("aw_id", 32'(s_awid_o), 32'd0);
                    end
                end
                if (w_f) begin
                    w_total++;
                    if (w_exp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w_extra actual=%0h required=no_beat", s_wdata_o);
                    end else begin
                        logic [32:0] e;
                        e = w_exp.pop_front();
                        chk("w_data", s_wdata_o, e[31:0]);
                        chk("w_last", 32'(s_wlast_o), 32'(e[32]));
                    end
                end
                if (b_f) begin
                    b_total++;
                    last_b_cyc = cyc;
                end
                if (frame_done_o) begin
                    chk("done_single_pulse", 32'(prev_done), 32'd0);
                    done_cyc = cyc;
                    done_cnt++;
                end
                prev_done = frame_done_o;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    // Slave and pixel source: drive just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (w_f) pix_idx++;
            pix_data_i = PIX_BASE + 32'(pix_idx);
            if (!rst_n || b_f) s_bvalid_i = 1'b0;
            if (wl_f && rst_n) begin
                s_bvalid_i = 1'b1;
                s_bresp_i  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
            end
            s_awready_i = (aw_hold == 0);
            if (aw_hold > 0) aw_hold--;
            s_wready_i  = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_valid_i = pv_toggle ? ~pix_valid_i : 1'b1;
        end
    end

    // Issues a frame request and pushes the expected AW addresses and W beats.
    task automatic start_frame(input logic [31:0] base, input logic [15:0] nb, input bit expect_it);
        @(posedge clk);
        #1;
        frame_start_i  = 1'b1;
        base_addr_i    = base;
        frame_bursts_i = nb;
        if (expect_it) begin
            for (int b = 0; b < int'(nb); b++)
                aw_exp.push_back((base & 32'hFFFF_FFFC) + 32'(b * 16));
            for (int i = 0; i < int'(nb) * 4; i++)
                w_exp.push_back({(i % 4 == 3), PIX_BASE + 32'(pix_idx + i)});
        end
        @(posedge clk);
        #1;
        frame_start_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no_frame_done required=frame_done", name);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int d0, b0, w0, n;
        rst_n = 1'b0; frame_start_i = 1'b0; base_addr_i = '0; frame_bursts_i = '0;
        pix_data_i = PIX_BASE; pix_valid_i = 1'b0; s_awready_i = 1'b1; s_wready_i = 1'b1;
        s_bid_i = 5'd3; s_bresp_i = 2'b00; s_bvalid_i = 1'b0;
        #2;
        chk("rst_awvalid", 32'(s_awvalid_o), 0);
        chk("rst_wvalid", 32'(s_wvalid_o), 0);
        chk("rst_pix_ready", 32'(pix_ready_o), 0);
        chk("rst_wlast", 32'(s_wlast_o), 0);
        chk("rst_bready", 32'(s_bready_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(frame_done_o), 0);
        chk("rst_err", 32'(resp_err_o), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Two bursts, always-ready slave; a mid-frame request must be ignored.
        d0 = done_cnt; b0 = b_total; w0 = w_total;
        start_frame(32'h1000_0000, 16'd2, 1'b1);
        start_frame(32'h5555_0000, 16'd7, 1'b0);
        wait_done(d0, "basic");
        chk("basic_beats", 32'(w_total - w0), 8);
        chk("basic_bursts", 32'(b_total - b0), 2);
        chk("basic_done_gap", 32'(done_cyc - last_b_cyc), 1);
        chk("basic_err", 32'(resp_err_o), 0);
        @(negedge clk);
        chk("basic_idle", 32'(busy_o), 0);

        // AW stall: address and length held, no pixel accepted.
        d0 = done_cnt;
        aw_hold = 8;
        start_frame(32'h2000_0040, 16'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_awvalid", 32'(s_awvalid_o), 1);
            chk("stall_awaddr", s_awaddr_o, 32'h2000_0040);
            chk("stall_awlen", 32'(s_awlen_o), 3);
            chk("stall_pix_ready", 32'(pix_ready_o), 0);
        end
        wait_done(d0, "stall");

        // Toggling pixel valid and random write-ready.
        d0 = done_cnt; w0 = w_total;
        wr_rand = 1; pv_toggle = 1;
        start_frame(32'h3000_0000, 16'd3, 1'b1);
        wait_done(d0, "random");
        wr_rand = 0; pv_toggle = 0;
        chk("random_beats", 32'(w_total - w0), 12);

        // Address wrap.
        d0 = done_cnt;
        start_frame(32'hFFFF_FFF0, 16'd2, 1'b1);
        wait_done(d0, "wrap");

        // Error response on the first of three bursts: sticky, frame still completes.
        d0 = done_cnt; b0 = b_total;
        resp_q.push_back(2'b10); resp_q.push_back(2'b00); resp_q.push_back(2'b00);
        start_frame(32'h4000_0000, 16'd3, 1'b1);
        n = 0;
        while (b_total == b0 && n < 300) begin @(posedge clk); n++; end
        @(negedge clk);
        chk("err_set", 32'(resp_err_o), 1);
        wait_done(d0, "err");
        chk("err_bursts", 32'(b_total - b0), 3);
        chk("err_sticky", 32'(resp_err_o), 1);
        d0 = done_cnt;
        start_frame(32'h4000_1003, 16'd1, 1'b1);
        chk("err_cleared", 32'(resp_err_o), 0);
        wait_done(d0, "err_clear");

        // Reset during the second W beat.
        w0 = w_total;
        start_frame(32'h5000_0000, 16'd2, 1'b1);
        n = 0;
        while (w_total == w0 && n < 300) begin @(posedge clk); n++; end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wvalid", 32'(s_wvalid_o), 0);
        chk("midrst_pix_ready", 32'(pix_ready_o), 0);
        chk("midrst_wlast", 32'(s_wlast_o), 0);
        chk("midrst_awvalid", 32'(s_awvalid_o), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        aw_exp.delete(); w_exp.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_busy", 32'(busy_o), 0);
        chk("postrst_awvalid", 32'(s_awvalid_o), 0);

        // Empty frame: done pulse with no AW.
        start_frame(32'h6000_0000, 16'd0, 1'b1);
        chk("empty_done", 32'(frame_done_o), 1);
        chk("empty_busy", 32'(busy_o), 0);
        chk("empty_awvalid", 32'(s_awvalid_o), 0);
        @(posedge clk);
        #1;
        chk("empty_done_clear", 32'(frame_done_o), 0);

        // Recovery after reset.
        d0 = done_cnt;
        start_frame(32'h7000_0000, 16'd1, 1'b1);
        wait_done(d0, "recover");
        repeat (2) @(posedge clk);

        chk("aw_queue_empty", 32'(aw_exp.size()), 0);
        chk("w_queue_empty", 32'(w_exp.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
